// File: rtl/conv3x3_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream_if
// Brief    : Pixel-in / result-out bundle for the 3x3 streaming convolver.
// Revision : 1.0
// ============================================================================
interface conv3x3_stream_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] pixel_in;
    logic [9*DATA_W-1:0]      weights;
    logic signed [ACC_W-1:0]  conv_out;
    logic                     out_valid;
    logic                     frame_done;

    modport master (
        output in_valid, pixel_in, weights,
        input  conv_out, out_valid, frame_done
    );

    modport slave (
        input  in_valid, pixel_in, weights,
        output conv_out, out_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Raster-order 3x3 valid-only convolution: line delays, window,
//            registered products, registered adder tree.
// Revision : 1.0
// ============================================================================
module conv3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int ACC_W  = 20
) (
    input  wire logic       clk,
    input  wire logic       rst,
    conv3x3_stream_if.slave bus
);
    localparam int                 c_CNT_W = $clog2(IMG_W);
    localparam int                 c_PW    = 2 * DATA_W;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(IMG_W - 1);
    localparam logic [c_CNT_W-1:0] c_TWO   = c_CNT_W'(2);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0]       r_col;
    logic [c_CNT_W-1:0]       r_row;
    logic signed [DATA_W-1:0] r_lb1 [IMG_W];
    logic signed [DATA_W-1:0] r_lb2 [IMG_W];
    logic signed [DATA_W-1:0] r_win [9];
    logic signed [c_PW-1:0]   r_prod [9];
    logic                     r_win_vld;
    logic                     r_win_last;
    logic                     r_p_vld;
    logic                     r_p_last;
    logic signed [ACC_W-1:0]  r_conv;
    logic                     r_ovalid;
    logic                     r_fdone;

    logic                     w_accept;
    logic                     w_complete;
    logic                     w_last;
    logic signed [c_PW-1:0]   w_px [9];
    logic signed [c_PW-1:0]   w_wt [9];
    logic signed [ACC_W-1:0]  w_sum;

    assign w_accept   = bus.in_valid;
    assign w_complete = w_accept && (r_row >= c_TWO) && (r_col >= c_TWO);
    assign w_last     = (r_row == c_LAST) && (r_col == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + c_ONE;
            end else begin
                r_col <= r_col + c_ONE;
            end
        end
    end

    // Each line delay holds exactly one row, so its tail is the pixel directly above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
            for (int k = 0; k < 9; k++) r_win[k] <= '0;
        end else if (w_accept) begin
            r_lb1[0] <= bus.pixel_in;
            r_lb2[0] <= r_lb1[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
            r_win[2] <= r_lb2[IMG_W-1];
            r_win[5] <= r_lb1[IMG_W-1];
            r_win[8] <= bus.pixel_in;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_px[k] = {{DATA_W{r_win[k][DATA_W-1]}}, r_win[k]};
            w_wt[k] = {{DATA_W{bus.weights[k*DATA_W+DATA_W-1]}},
                       bus.weights[k*DATA_W +: DATA_W]};
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(ACC_W-c_PW){r_prod[k][c_PW-1]}}, r_prod[k]};
        end
    end

    // Free-running pipeline: input gaps never stall in-flight windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= '0;
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            r_p_vld    <= 1'b0;
            r_p_last   <= 1'b0;
            r_conv     <= '0;
            r_ovalid   <= 1'b0;
            r_fdone    <= 1'b0;
        end else begin
            r_win_vld  <= w_complete;
            r_win_last <= w_complete && w_last;
            for (int k = 0; k < 9; k++) r_prod[k] <= w_px[k] * w_wt[k];
            r_p_vld    <= r_win_vld;
            r_p_last   <= r_win_last;
            r_ovalid   <= r_p_vld;
            r_fdone    <= r_p_last;
            if (r_p_vld) r_conv <= w_sum;
        end
    end

    assign bus.conv_out   = r_conv;
    assign bus.out_valid  = r_ovalid;
    assign bus.frame_done = r_fdone;
endmodule
`default_nettype wire
